register_file: RTL
==================

// Module: register_file
// PURPOSE
//  32x32 general-purpose register file for the 5-stage pipeline. Two asynchronous read ports serve decode; one synchronous write port serves writeback.
//  - Register 0 is hardwired to zero.
//  - The storage array is not reset. A post-reset clear sequencer zeroes every entry, one per clock, and then raises ready.
// PARAMETERS
//  DATA_W   32  register width in bits
//  DEPTH    32  number of architectural registers (power of 2, <= 2**ADDR_W)
//  ADDR_W   6   address port width; matches the pipeline's register_file_* ports
// PORTS
//  clock                          in   1       rising-edge clock
//  reset_n                        in   1       asynchronous, active-low reset
//  register_file_read_address_1   in   ADDR_W  read port 1 address
//  register_file_read_address_2   in   ADDR_W  read port 2 address
//  register_file_read_value_1     out  DATA_W  read port 1 data (combinational)
//  register_file_read_value_2     out  DATA_W  read port 2 data (combinational)
//  register_file_write_address    in   ADDR_W  write address
//  register_file_write_value      in   DATA_W  write data
//  register_file_write_enable     in   1       write strobe, sampled at posedge clock
//  ready                          out  1       high once the clear sequence has finished
// BEHAVIOUR
//  Reset (reset_n low, asynchronous):
//  - state=CLEAR, clear_ptr=0, ready=0.
//  - Read outputs are 0 for the whole time ready=0.
//  - Array contents are undefined until cleared.
//  Clear sequence:
//  - CLEAR: each clock writes 0 to entry clear_ptr, then clear_ptr+1.
//  - At clear_ptr==DEPTH-1: write 0, go to RUN, set ready=1 on that same edge.
//  - Total: DEPTH clocks after reset_n rises before ready=1.
//  RUN:
//  - Write occurs at posedge when write_enable=1, address!=0 and address<DEPTH.
//  - Writes to address 0 or to address>=DEPTH are silently dropped.
//  - Read of address 0, or of address>=DEPTH, returns 0. Any other read returns the stored entry.
//  - Read-to-data latency is 0 cycles (combinational). Write-to-array latency is 1 edge.
//  Boundary conditions:
//  - write_enable during CLEAR: the write is dropped; the clear value wins.
//  - reset_n asserted mid-CLEAR or in RUN: immediate return to CLEAR with ptr=0 and ready=0. The full clear restarts.
//  - Both read ports on the same address: both return identical data.
//  - Address bit ADDR_W-1 set: out of range when DEPTH=32, so it follows the >=DEPTH rules.
//  - clear_ptr is a counter of width log2(DEPTH); it never wraps in RUN.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined (write-first):
//  - If write_enable=1 and the write address equals a read address (nonzero, <DEPTH, ready=1), that read port returns register_file_write_value in the same cycle.
//  REGFILE_BYPASS_EN undefined (read-old):
//  - The read port returns the stored (old) value; the new value is visible from the next cycle.
//  - The decode-stage forwarding covers the writeback address in this mode.
// STRUCTURE
//  Shared package processor_pkg holds:
//  - DATA_W, ADDR_W, REG_ZERO=0
//  - clear-FSM state encoding: CLEAR=1'b0, RUN=1'b1
//  Sub-module regfile_clear_seq: the FSM plus clear_ptr.
//  - Outputs: clear_we, clear_addr, ready.
//  - It owns all reset-sensitive state.
//  The top level contains the array, the write mux (clear vs pipeline), the read muxes and the optional bypass.
// TESTING
//  1. Clear timing: release reset_n, count clocks.
//     -> ready rises exactly 32 edges later.
//     -> Every address then reads 0.
//  2. Basic write/read: write 0xDEADBEEF to r5 at cycle N.
//     -> Port 1 reads 0xDEADBEEF at address 5 from cycle N+1.
//     -> Port 2 at r6 reads 0.
//  3. Zero/out-of-range: write 0x1234 to r0 and to address 40.
//     -> r0 reads 0, address 40 reads 0.
//     -> r8 (aliasing candidate) is unchanged.
//  4. Same-cycle write/read of r7, new value 0xA5A5A5A5, old value 0x11.
//     -> With BYPASS_EN: reads 0xA5A5A5A5.
//     -> Without: reads 0x11, then 0xA5A5A5A5 the next cycle.
//  5. Reset mid-clear: assert reset_n low at clear cycle 10, release it.
//     -> ready stays 0 for a full 32 cycles after release.
//     -> Pre-reset r3=0x77 reads 0 afterwards.
//  6. Write during CLEAR: write_enable=1 with r4=0x99 at clear cycle 2.
//     -> After ready=1, r4 reads 0.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared pipeline definitions: datapath widths, the hardwired-zero register
// index, and the state encoding of the register-file clear sequencer.
package processor_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 6;
   localparam int REG_ZERO = 0;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } clear_state_t;

endpackage : processor_pkg

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer for the register file. Walks clear_ptr from 0 to
// DEPTH-1, asking the array to write zero at each step, then parks in RUN and
// raises ready. Holds all reset-sensitive state of the register file.
module regfile_clear_seq #(
   parameter int DEPTH = 32,
   parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             reset_n,
   output logic             clear_we,
   output logic [PTR_W-1:0] clear_addr,
   output logic             ready
);
   import processor_pkg::*;

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   clear_state_t     state, state_nxt;
   logic [PTR_W-1:0] clear_ptr, clear_ptr_nxt;

   // State and pointer registers; reset restarts the full clear.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= CLEAR;
         clear_ptr <= '0;
      end else begin
         state     <= state_nxt;
         clear_ptr <= clear_ptr_nxt;
      end
   end

   // Next-state logic: step the pointer while clearing, stop at the last entry.
   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt     = state;
      clear_ptr_nxt = clear_ptr;
      clear_we      = 1'b0;
      if (state == CLEAR) begin
         clear_we = 1'b1;
         if (clear_ptr == LAST_PTR) begin
            state_nxt = RUN;
         end else begin
            clear_ptr_nxt = clear_ptr + 1'b1;
         end
      end
   end

   assign clear_addr = clear_ptr;
   assign ready      = (state == RUN);

endmodule : regfile_clear_seq

// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one write port.
// Register 0 reads as zero; addresses >= DEPTH are ignored on write and read
// as zero. The array is zeroed by regfile_clear_seq after every reset, and the
// read ports return zero until that finishes.
// Optional feature: define REGFILE_BYPASS_EN for write-first reads (a read of
// the address being written returns the incoming write value); otherwise the
// read returns the old stored value until the next cycle.
module register_file #(
   parameter int DATA_W = processor_pkg::DATA_W,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = processor_pkg::ADDR_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] register_file_read_address_1,
   input  logic [ADDR_W-1:0] register_file_read_address_2,
   output logic [DATA_W-1:0] register_file_read_value_1,
   output logic [DATA_W-1:0] register_file_read_value_2,
   input  logic [ADDR_W-1:0] register_file_write_address,
   input  logic [DATA_W-1:0] register_file_write_value,
   input  logic              register_file_write_enable,
   output logic              ready
);
   import processor_pkg::*;

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic             clear_we;
   logic [IDX_W-1:0] clear_addr;
   logic             pipe_we;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [DATA_W-1:0] wr_data;

   // An address names a writable/readable entry: not r0 and inside the array.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a != ADDR_W'(REG_ZERO)) && ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
   endfunction

   regfile_clear_seq #(
      .DEPTH (DEPTH),
      .PTR_W (IDX_W)
   ) u_clear_seq (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear_we   (clear_we),
      .clear_addr (clear_addr),
      .ready      (ready)
   );

   assign pipe_we = ready && register_file_write_enable && addr_ok(register_file_write_address);

   // Write mux: the clear sequencer owns the port until ready, then writeback.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = clear_addr;
      wr_data = '0;
      if (clear_we) begin
         wr_en = 1'b1;
      end else if (pipe_we) begin
         wr_en   = 1'b1;
         wr_idx  = register_file_write_address[IDX_W-1:0];
         wr_data = register_file_write_value;
      end
   end

   // Storage array write.
   // NOTE: the array has no reset; it is zeroed by the clear sequence instead.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Read muxes: zero until ready and for r0 / out-of-range, optional bypass.
   always_comb begin
      register_file_read_value_1 = '0;
      register_file_read_value_2 = '0;
      if (ready && addr_ok(register_file_read_address_1)) begin
         register_file_read_value_1 = mem[register_file_read_address_1[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
         if (pipe_we && (register_file_read_address_1 == register_file_write_address)) begin
            register_file_read_value_1 = register_file_write_value;
         end
`endif
      end
      if (ready && addr_ok(register_file_read_address_2)) begin
         register_file_read_value_2 = mem[register_file_read_address_2[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
         if (pipe_we && (register_file_read_address_2 == register_file_write_address)) begin
            register_file_read_value_2 = register_file_write_value;
         end
`endif
      end
   end

endmodule : register_file
